// File: rtl/decode_issue.sv
// Decode/issue stage: decodes MIPS fields, interlocks RAW/WAW hazards with a
// scoreboard, and delays writeback clears until the register set shows the data.
module decode_issue #(
    parameter int WB_VIS = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    output logic [4:0]  rnum1,
    output logic [4:0]  rnum2,
    input  logic        wb_valid,
    input  logic [4:0]  wb_num,
    input  logic [31:0] wb_data,
    output logic        write,
    output logic [4:0]  wnum,
    output logic [31:0] wdata,
    output logic        ex_valid,
    output logic [5:0]  ex_opcode,
    output logic [5:0]  ex_funct,
    output logic [4:0]  ex_shamt,
    output logic [31:0] ex_imm,
    output logic [25:0] ex_target,
    output logic [4:0]  ex_dest,
    output logic        ex_illegal
);

    logic        r_d_valid;
    logic [31:0] r_d_instr;
    logic [31:0] r_sb;
    logic [WB_VIS-1:0] r_dl_v;
    logic [4:0]  r_dl_n [WB_VIS];

    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic        w_use_rs;
    logic        w_use_rt;
    logic [4:0]  w_dest;
    logic        w_illegal;
    logic        w_hazard;
    logic        w_issue;
    logic [31:0] w_set;
    logic [31:0] w_clr;

    assign w_op    = r_d_instr[31:26];
    assign w_funct = r_d_instr[5:0];
    assign w_rs    = r_d_instr[25:21];
    assign w_rt    = r_d_instr[20:16];
    assign w_rd    = r_d_instr[15:11];

    always_comb begin
        w_use_rs  = 1'b0;
        w_use_rt  = 1'b0;
        w_dest    = 5'd0;
        w_illegal = 1'b0;
        case (w_op)
            6'h00: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
                w_dest   = (w_funct == 6'h08) ? 5'd0 : w_rd;
            end
            6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23: begin
                w_use_rs = 1'b1;
                w_dest   = w_rt;
            end
            6'h0F: w_dest = w_rt;
            6'h2B, 6'h04, 6'h05: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            6'h02: w_dest = 5'd0;
            6'h03: w_dest = 5'd31;
            default: w_illegal = 1'b1;
        endcase
    end

    // Register 0 is never marked busy, so it can never block.
    assign w_hazard = r_d_valid &&
        ((w_use_rs && w_rs != 5'd0 && r_sb[w_rs]) ||
         (w_use_rt && w_rt != 5'd0 && r_sb[w_rt]) ||
         (w_dest != 5'd0 && r_sb[w_dest]));
    assign w_issue  = r_d_valid && !w_hazard;
    assign if_ready = !r_d_valid || w_issue;

    assign rnum1 = r_d_valid ? w_rs : 5'd0;
    assign rnum2 = r_d_valid ? w_rt : 5'd0;

    assign write = wb_valid;
    assign wnum  = wb_num;
    assign wdata = wb_data;

    assign w_set = (w_issue && w_dest != 5'd0) ? (32'd1 << w_dest) : 32'd0;
    assign w_clr = r_dl_v[WB_VIS-1] ? (32'd1 << r_dl_n[WB_VIS-1]) : 32'd0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_valid <= 1'b0;
            r_d_instr <= 32'd0;
        end else if (if_valid && if_ready) begin
            r_d_valid <= 1'b1;
            r_d_instr <= if_instr;
        end else if (w_issue) begin
            r_d_valid <= 1'b0;
        end
    end

    // Set is applied after clear so a same-edge set wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_sb <= 32'd0;
        else          r_sb <= (r_sb & ~w_clr) | w_set;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dl_v <= '0;
            for (int i = 0; i < WB_VIS; i++) r_dl_n[i] <= 5'd0;
        end else begin
            r_dl_v[0] <= wb_valid && (wb_num != 5'd0);
            r_dl_n[0] <= wb_num;
            for (int i = 1; i < WB_VIS; i++) begin
                r_dl_v[i] <= r_dl_v[i-1];
                r_dl_n[i] <= r_dl_n[i-1];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid   <= 1'b0;
            ex_opcode  <= 6'd0;
            ex_funct   <= 6'd0;
            ex_shamt   <= 5'd0;
            ex_imm     <= 32'd0;
            ex_target  <= 26'd0;
            ex_dest    <= 5'd0;
            ex_illegal <= 1'b0;
        end else begin
            ex_valid <= w_issue;
            if (w_issue) begin
                ex_opcode  <= w_op;
                ex_funct   <= w_funct;
                ex_shamt   <= r_d_instr[10:6];
                ex_imm     <= {{16{r_d_instr[15]}}, r_d_instr[15:0]};
                ex_target  <= r_d_instr[25:0];
                ex_dest    <= w_dest;
                ex_illegal <= w_illegal;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios then random traffic, all checked
// against a transaction-level scoreboard model with timed clear events.
module tb_decode_issue;

    localparam int WB_VIS = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = 32'd0;
    logic        if_ready;
    logic [4:0]  rnum1, rnum2;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_num = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        write;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        ex_valid;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_imm;
    logic [25:0] ex_target;
    logic [4:0]  ex_dest;
    logic        ex_illegal;

    decode_issue #(.WB_VIS(WB_VIS)) dut (
        .clock(clock), .reset_n(reset_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .rnum1(rnum1), .rnum2(rnum2),
        .wb_valid(wb_valid), .wb_num(wb_num), .wb_data(wb_data),
        .write(write), .wnum(wnum), .wdata(wdata),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_shamt(ex_shamt), .ex_imm(ex_imm), .ex_target(ex_target),
        .ex_dest(ex_dest), .ex_illegal(ex_illegal)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    typedef struct {
        int r;
        int due;
    } clr_t;

    bit          m_busy [32];
    clr_t        m_q [$];
    bit          m_dv;
    logic [31:0] m_di;
    bit          m_exv;
    logic [31:0] m_exi;
    int          m_exdest;
    bit          m_exill;
    int          cyc = 0;

    localparam logic [31:0] ADDI8 = 32'h20080005;
    localparam logic [31:0] ADD9  = 32'h01084820;
    localparam logic [31:0] LW8   = 32'h8FA8FFFC;
    localparam logic [31:0] ILL   = 32'hFC000000;
    localparam logic [31:0] ADD0  = 32'h014B0020;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // What an instruction reads and writes, straight from the opcode table.
    task automatic classify(input logic [31:0] ins, output int rs, output int rt,
                            output int dest, output bit ill);
        int op = int'(ins[31:26]);
        rs = -1; rt = -1; dest = 0; ill = 0;
        if (op == 0) begin
            rs = int'(ins[25:21]); rt = int'(ins[20:16]);
            dest = (ins[5:0] == 6'h08) ? 0 : int'(ins[15:11]);
        end else if (op inside {8, 9, 10, 12, 13, 14, 35}) begin
            rs = int'(ins[25:21]); dest = int'(ins[20:16]);
        end else if (op == 15) begin
            dest = int'(ins[20:16]);
        end else if (op inside {43, 4, 5}) begin
            rs = int'(ins[25:21]); rt = int'(ins[20:16]);
        end else if (op == 3) begin
            dest = 31;
        end else if (op != 2) begin
            ill = 1;
        end
    endtask

    function automatic bit blocked(int r);
        return r > 0 && m_busy[r];
    endfunction

    task automatic model_reset();
        foreach (m_busy[i]) m_busy[i] = 0;
        m_q.delete();
        m_dv = 0; m_di = 0;
        m_exv = 0; m_exi = 0; m_exdest = 0; m_exill = 0;
    endtask

    function automatic logic [31:0] busy_vec();
        logic [31:0] v = 0;
        foreach (m_busy[i]) v[i] = m_busy[i];
        return v;
    endfunction

    // One clock: check all outputs at the negedge, then advance the model.
    task automatic stp(input bit v, input logic [31:0] ins, input bit wv = 0,
                       input logic [4:0] wn = 0, input logic [31:0] wd = 0);
        int rs, rt, dest;
        bit ill, iss, rdy;
        clr_t keep [$];
        if_valid = v; if_instr = ins;
        wb_valid = wv; wb_num = wn; wb_data = wd;
        @(negedge clock);
        classify(m_di, rs, rt, dest, ill);
        iss = m_dv && !(blocked(rs) || blocked(rt) || blocked(dest));
        rdy = !m_dv || iss;
        chk("if_ready", if_ready, rdy);
        chk("rnum1", rnum1, m_dv ? m_di[25:21] : 5'd0);
        chk("rnum2", rnum2, m_dv ? m_di[20:16] : 5'd0);
        chk("wport", {write, wnum, wdata}, {wv, wn, wd});
        chk("ex_valid", ex_valid, m_exv);
        chk("ex_fields", {ex_opcode, ex_funct, ex_shamt, ex_target},
            {m_exi[31:26], m_exi[5:0], m_exi[10:6], m_exi[25:0]});
        chk("ex_imm", ex_imm, {{16{m_exi[15]}}, m_exi[15:0]});
        chk("ex_dest_ill", {ex_dest, ex_illegal}, {m_exdest[4:0], m_exill});
        chk("scoreboard", dut.r_sb, busy_vec());
        foreach (m_q[i]) begin
            if (m_q[i].due == cyc) m_busy[m_q[i].r] = 0;
            else keep.push_back(m_q[i]);
        end
        m_q = keep;
        if (iss && dest != 0) m_busy[dest] = 1;
        if (wv && wn != 0) m_q.push_back('{r: int'(wn), due: cyc + WB_VIS});
        m_exv = iss;
        if (iss) begin
            m_exi = m_di; m_exdest = dest; m_exill = ill;
        end
        if (v && rdy) begin
            m_dv = 1; m_di = ins;
        end else if (iss) begin
            m_dv = 0;
        end
        cyc++;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        if_valid = 0; wb_valid = 0;
        model_reset();
        #1;
        chk("rst_sb", dut.r_sb, 32'd0);
        chk("rst_ready", if_ready, 1'b1);
        chk("rst_exv", ex_valid, 1'b0);
        chk("rst_ex", {ex_dest, ex_imm, ex_illegal, ex_target}, 64'd0);
        chk("rst_rnum", {rnum1, rnum2}, 10'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc += 2;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [10] = '{6'h00, 6'h08, 6'h23, 6'h0F, 6'h2B,
                                 6'h04, 6'h02, 6'h03, 6'h3F, 6'h0D};
        logic [31:0] ins = $urandom;
        ins[31:26] = ops[$urandom_range(0, 9)];
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        if (ins[31:26] == 6'h00) ins[5:0] = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'h20;
        return ins;
    endfunction

    initial begin
        model_reset();
        #2;
        do_reset();

        // Simple issue
        stp(1, ADDI8);
        stp(0, 0);
        chk("addi_exv", ex_valid, 1'b1);
        chk("addi_dest", ex_dest, 5'd8);
        chk("addi_imm", ex_imm, 32'd5);
        chk("addi_sb8", dut.r_sb[8], 1'b1);

        // RAW stall released by delayed writeback clear
        stp(1, ADD9);
        stp(0, 0);
        chk("raw_stall", if_ready, 1'b0);
        stp(0, 0, 1, 5'd8, 32'h1234);
        stp(0, 0);
        stp(0, 0);
        chk("raw_sb8_held", dut.r_sb[8], 1'b1);
        stp(0, 0);
        chk("raw_sb8_clr", dut.r_sb[8], 1'b0);
        chk("raw_rnum", {rnum1, rnum2}, {5'd8, 5'd8});
        stp(0, 0);
        chk("raw_issue", {ex_valid, ex_dest}, {1'b1, 5'd9});

        // Negative immediate
        stp(1, LW8);
        stp(0, 0);
        chk("lw_imm", ex_imm, 32'hFFFFFFFC);
        chk("lw_dest", ex_dest, 5'd8);

        // Second clear for r8 matures on the edge a new r8 writer issues
        stp(1, ADDI8);
        stp(0, 0, 1, 5'd8, 32'd1);
        stp(0, 0, 1, 5'd8, 32'd2);
        stp(0, 0);
        stp(0, 0);
        stp(0, 0);
        chk("setwins_exv", ex_valid, 1'b1);
        chk("setwins_sb8", dut.r_sb[8], 1'b1);
        stp(0, 0, 1, 5'd8, 32'd3);
        repeat (4) stp(0, 0);
        chk("r8_free", dut.r_sb[8], 1'b0);

        // Illegal and dest-0 instructions
        stp(1, ILL);
        stp(1, ADD0);
        chk("ill_exv", {ex_valid, ex_illegal, ex_dest}, {1'b1, 1'b1, 5'd0});
        stp(0, 0);
        chk("add0", {ex_valid, ex_illegal, ex_dest}, {1'b1, 1'b0, 5'd0});
        chk("add0_sb", dut.r_sb, 32'h200);

        // Reset during a stall with a clear in flight
        stp(1, ADDI8);
        stp(0, 0);
        stp(1, ADD9);
        stp(0, 0, 1, 5'd8, 32'd4);
        stp(0, 0);
        do_reset();
        stp(1, ADDI8);
        stp(0, 0);
        repeat (5) stp(0, 0);
        chk("no_stray_clr", dut.r_sb[8], 1'b1);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            bit wv = ($urandom_range(0, 2) == 0);
            stp($urandom_range(0, 1), rand_instr(), wv,
                5'($urandom_range(0, 8)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
